// File: rtl/reg_file_cc.sv
// reg_file_cc: LC-3 general-purpose registers, NZP condition codes and BEN latch
module reg_file_cc #(
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] REG_RST_VAL = '0,
    parameter logic [2:0]        CC_RST_VAL  = 3'b010
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [DATA_W-1:0] i_Bus,
    input  logic [15:0]       i_IR,
    input  logic              i_LD_REG,
    input  logic              i_LD_CC,
    input  logic              i_LD_BEN,
    input  logic [1:0]        i_DRMUX,
    input  logic [1:0]        i_SR1MUX,
    output logic [DATA_W-1:0] o_RegFile_Out,
    output logic [DATA_W-1:0] o_SR2_Reg,
    output logic              o_N,
    output logic              o_Z,
    output logic              o_P,
    output logic              o_BEN
);
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];
    logic [2:0]        nzp_q, nzp_d;
    logic              ben_q, ben_d;
    logic [2:0]        dr, sr1;

    always_comb begin
        dr  = i_DRMUX == 2'b01 ? 3'd7 : i_DRMUX == 2'b10 ? 3'd6 : i_IR[11:9];
        sr1 = i_SR1MUX == 2'b01 ? i_IR[8:6] : i_SR1MUX == 2'b10 ? 3'd6 : i_IR[11:9];
        regs_d = regs_q;
        if (i_LD_REG) regs_d[dr] = i_Bus;
        nzp_d = i_LD_CC ? {i_Bus[DATA_W-1], i_Bus == '0, ~i_Bus[DATA_W-1] & (|i_Bus)} : nzp_q;
        ben_d = i_LD_BEN ? |(i_IR[11:9] & nzp_q) : ben_q;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            regs_q <= '{default: REG_RST_VAL};
            nzp_q  <= CC_RST_VAL;
            ben_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            nzp_q  <= nzp_d;
            ben_q  <= ben_d;
        end
    end

    assign o_RegFile_Out     = regs_q[sr1];
    assign o_SR2_Reg         = regs_q[i_IR[2:0]];
    assign {o_N, o_Z, o_P}   = nzp_q;
    assign o_BEN             = ben_q;
endmodule

// File: tb/tb_reg_file_cc.sv
// tb_reg_file_cc: directed self-checking bench for reg_file_cc
module tb_reg_file_cc;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus, ir;
    logic        ld_reg, ld_cc, ld_ben;
    logic [1:0]  drmux, sr1mux;
    logic [15:0] rf_out, sr2;
    logic        n, z, p, ben;
    int          passed = 0;
    int          total = 0;

    reg_file_cc dut (
        .i_Clk(clk), .i_Reset(rst), .i_Bus(bus), .i_IR(ir),
        .i_LD_REG(ld_reg), .i_LD_CC(ld_cc), .i_LD_BEN(ld_ben),
        .i_DRMUX(drmux), .i_SR1MUX(sr1mux),
        .o_RegFile_Out(rf_out), .o_SR2_Reg(sr2),
        .o_N(n), .o_Z(z), .o_P(p), .o_BEN(ben)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; bus = 16'hFFFF; ir = 16'h0E00; ld_reg = 1'b1; ld_cc = 1'b1; ld_ben = 1'b1;
        drmux = 2'b00; sr1mux = 2'b00;
        tick(); tick();
        rst = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0; ld_ben = 1'b0;
        #1;
        check("rst_nzp", {13'd0, n, z, p}, 16'h0002);
        check("rst_ben", {15'd0, ben}, 16'h0000);
        check("rst_r7", rf_out, 16'h0000);
        check("rst_r0", sr2, 16'h0000);

        ir = 16'h0A00; bus = 16'h1234; ld_reg = 1'b1;
        #1 check("wr_old", rf_out, 16'h0000);
        tick(); ld_reg = 1'b0;
        check("wr_r5", rf_out, 16'h1234);

        drmux = 2'b01; bus = 16'hBEEF; ld_reg = 1'b1; tick();
        drmux = 2'b10; bus = 16'h3000; tick();
        ld_reg = 1'b0; drmux = 2'b00;
        sr1mux = 2'b10;
        #1 check("sr1_r6", rf_out, 16'h3000);
        ir = 16'h01C6; sr1mux = 2'b01;
        #1 check("sr1_ir86", rf_out, 16'hBEEF);
        check("sr2_r6", sr2, 16'h3000);
        ir = 16'h0A00; sr1mux = 2'b11;
        #1 check("sr1_sel11", rf_out, 16'h1234);

        ir = 16'h0200; drmux = 2'b11; bus = 16'h5555; ld_reg = 1'b1; tick();
        ld_reg = 1'b0; drmux = 2'b00; sr1mux = 2'b00;
        #1 check("dr_sel11", rf_out, 16'h5555);
        ir = 16'h0E00;
        #1 check("r7_kept", rf_out, 16'hBEEF);

        ld_cc = 1'b1;
        bus = 16'h8000; tick(); check("cc_8000", {13'd0, n, z, p}, 16'h0004);
        bus = 16'h0000; tick(); check("cc_0000", {13'd0, n, z, p}, 16'h0002);
        bus = 16'h7FFF; tick(); check("cc_7fff", {13'd0, n, z, p}, 16'h0001);
        bus = 16'hFFFF; tick(); check("cc_ffff", {13'd0, n, z, p}, 16'h0004);
        ld_cc = 1'b0; bus = 16'h0000; tick();
        check("cc_hold", {13'd0, n, z, p}, 16'h0004);

        ld_ben = 1'b1;
        ir = 16'h0800; tick(); check("ben_brn", {15'd0, ben}, 16'h0001);
        ir = 16'h0400; tick(); check("ben_brz", {15'd0, ben}, 16'h0000);
        ir = 16'h0800; tick(); check("ben_brn2", {15'd0, ben}, 16'h0001);
        ir = 16'h0000; tick(); check("ben_none", {15'd0, ben}, 16'h0000);
        ld_ben = 1'b0; ir = 16'h0800; tick();
        check("ben_hold", {15'd0, ben}, 16'h0000);

        ld_cc = 1'b1; bus = 16'h0000; tick();
        ir = 16'h0400; bus = 16'h0005; ld_ben = 1'b1; tick();
        ld_cc = 1'b0; ld_ben = 1'b0;
        check("sim_ben", {15'd0, ben}, 16'h0001);
        check("sim_nzp", {13'd0, n, z, p}, 16'h0001);

        rst = 1'b1; ir = 16'h0A00; bus = 16'h8000; ld_reg = 1'b1; ld_cc = 1'b1; ld_ben = 1'b1;
        tick();
        rst = 1'b0; ld_reg = 1'b0; ld_cc = 1'b0; ld_ben = 1'b0;
        #1;
        check("mid_rst_r5", rf_out, 16'h0000);
        check("mid_rst_nzp", {13'd0, n, z, p}, 16'h0002);
        check("mid_rst_ben", {15'd0, ben}, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
